// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: word width, the canonical NOP and the IF/ID payload.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic            fetch_err;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with redirect > stall > +4 next-PC selection and a sticky misaligned-target flag.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_err_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (!stall_i) begin
      pc_d = pc_q + XLEN'(4);
    end
    misalign_d = misalign_q | (redirect_i & (|redirect_pc_i[1:0]));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o           = pc_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: drives the ROM word address from the PC and captures the fetched word into IF/ID.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ROM_DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  localparam int             AW        = $clog2(ROM_DEPTH)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [AW-1:0]   rom_addr,
  input  logic [XLEN-1:0] rom_data,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_fetch_err,
  output logic            misalign_err
);

  logic [XLEN-1:0] pc_q;
  logic            in_range;
  if_id_t          if_id_q, if_id_d;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i         (CLK),
    .rst_ni        (RESET_N),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc_q),
    .misalign_err_o(misalign_err)
  );

  // Addresses past the ROM fault instead of aliasing back onto low words.
  assign in_range = (pc_q[XLEN-1:AW+2] == '0);
  assign rom_addr = pc_q[AW+1:2];

  always_comb begin
    if_id_d = if_id_q;
    if (redirect) begin
      if_id_d.valid     = 1'b0;
      if_id_d.fetch_err = 1'b0;
      if_id_d.pc        = '0;
      if_id_d.instr     = NOP_INSTR;
    end else if (!stall) begin
      if_id_d.valid     = 1'b1;
      if_id_d.fetch_err = ~in_range;
      if_id_d.pc        = pc_q;
      if_id_d.instr     = in_range ? rom_data : NOP_INSTR;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      if_id_q.valid     <= 1'b0;
      if_id_q.fetch_err <= 1'b0;
      if_id_q.pc        <= '0;
      if_id_q.instr     <= NOP_INSTR;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_valid     = if_id_q.valid;
  assign if_id_instr     = if_id_q.instr;
  assign if_id_pc        = if_id_q.pc;
  assign if_id_fetch_err = if_id_q.fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational ROM holding word i = 0x1000_0000 + i.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESET_N;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_fetch_err;
  logic        misalign_err;

  logic [31:0] rom [1024];
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_fetch_err(if_id_fetch_err),
    .misalign_err   (misalign_err)
  );

  assign rom_data = rom[rom_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr, input logic err);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".err"}, 32'(if_id_fetch_err), 32'(err));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + 32'(i);
    RESET_N     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    @(negedge CLK);
    chk_ifid("rst", 1'b0, 32'h0, NOP, 1'b0);
    chk("rst.misalign", 32'(misalign_err), 32'h0);
    chk("rst.rom_addr", 32'(rom_addr), 32'h0);
    RESET_N = 1'b1;
    chk("pre_edge1.valid", 32'(if_id_valid), 32'h0);

    step(); chk_ifid("run0", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
    step(); chk_ifid("run1", 1'b1, 32'h4, 32'h1000_0001, 1'b0);
    step(); chk_ifid("run2", 1'b1, 32'h8, 32'h1000_0002, 1'b0);
    chk("run2.rom_addr", 32'(rom_addr), 32'h3);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid("stall", 1'b1, 32'h8, 32'h1000_0002, 1'b0);
      chk("stall.rom_addr", 32'(rom_addr), 32'h3);
    end
    stall = 1'b0;
    step(); chk_ifid("unstall", 1'b1, 32'hC, 32'h1000_0003, 1'b0);

    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step(); chk_ifid("redir_bubble", 1'b0, 32'h0, NOP, 1'b0);
    chk("redir.rom_addr", 32'(rom_addr), 32'h10);
    redirect = 1'b0; stall = 1'b0;
    step(); chk_ifid("redir_tgt", 1'b1, 32'h40, 32'h1000_0010, 1'b0);
    chk("redir.misalign", 32'(misalign_err), 32'h0);

    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    chk("mis.flag", 32'(misalign_err), 32'h1);
    chk("mis.rom_addr", 32'(rom_addr), 32'h10);
    redirect_pc = 32'h80;
    step();
    chk("mis.sticky", 32'(misalign_err), 32'h1);
    chk("mis2.rom_addr", 32'(rom_addr), 32'h20);

    redirect_pc = 32'hFFC;
    step();
    chk("top.rom_addr", 32'(rom_addr), 32'h3FF);
    redirect = 1'b0;
    step(); chk_ifid("last_word", 1'b1, 32'hFFC, 32'h1000_03FF, 1'b0);
    chk("oob.rom_addr", 32'(rom_addr), 32'h0);
    step(); chk_ifid("oob", 1'b1, 32'h1000, NOP, 1'b1);
    chk("oob.misalign", 32'(misalign_err), 32'h1);

    // Asynchronous reset between edges while a stall is held.
    stall = 1'b1;
    #2 RESET_N = 1'b0;
    #1;
    chk_ifid("async_rst", 1'b0, 32'h0, NOP, 1'b0);
    chk("async_rst.misalign", 32'(misalign_err), 32'h0);
    chk("async_rst.rom_addr", 32'(rom_addr), 32'h0);
    RESET_N = 1'b1;
    stall   = 1'b0;
    step(); chk_ifid("restart0", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
    step(); chk_ifid("restart1", 1'b1, 32'h4, 32'h1000_0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the single-issue RV32I core. Holds the program counter and drives the word address of the combinational instruction ROM (1024 x 32). It registers the returned instruction word and its PC into the IF/ID pipeline register for the decoder. Supports stall (hold) and branch/jump redirect with flush.

Parameters:
ROM_DEPTH, 1024, instruction ROM depth in 32-bit words; address width AW = $clog2(ROM_DEPTH)
XLEN, 32, PC and instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET_N  input  1  asynchronous, active-low reset
stall  input  1  hold PC and IF/ID register this cycle
redirect  input  1  taken branch/jump from EX; flush and load new PC
redirect_pc  input  XLEN  redirect target byte address
rom_addr  output  AW  word address to instruction ROM, combinational = pc[AW+1:2]
rom_data  input  XLEN  instruction word returned combinationally by ROM
if_id_valid  output  1  IF/ID holds a real instruction
if_id_instr  output  XLEN  registered instruction (NOP when not valid)
if_id_pc  output  XLEN  byte PC of if_id_instr
if_id_fetch_err  output  1  fetched PC outside ROM range; instr forced to NOP
misalign_err  output  1  sticky: a redirect target had [1:0] != 0

Behaviour:
- Reset (RESET_N=0, asynchronous, takes effect immediately): pc=RESET_PC, if_id_valid=0, if_id_instr=NOP (32'h0000_0013), if_id_pc=0, if_id_fetch_err=0, misalign_err=0. rom_addr follows pc, i.e. RESET_PC[AW+1:2].
- Priority per rising edge: redirect > stall > normal advance.
- Normal (redirect=0, stall=0): if_id_instr<=in_range ? rom_data : NOP; if_id_pc<=pc; if_id_valid<=1; if_id_fetch_err<=~in_range; pc<=pc+4.
- in_range = (pc[XLEN-1:AW+2]==0). Out-of-range fetch still marks valid=1 so decoder sees a NOP with the error flag set.
- Stall (redirect=0, stall=1): pc and all IF/ID outputs hold their values.
- Redirect (redirect=1, stall ignored): pc<={redirect_pc[XLEN-1:2],2'b00}; IF/ID loaded with bubble: valid=0, instr=NOP, pc=0, fetch_err=0. Instruction currently on rom_data is discarded.
- Misaligned redirect: redirect=1 and redirect_pc[1:0]!=0 sets misalign_err=1; it stays set until reset. The PC is still aligned down.
- Latency: instruction at PC p appears on if_id_instr one edge after pc==p with no stall or redirect. Throughput is 1 instruction/cycle. Redirect penalty is 1 bubble in IF/ID.
- Wrap: pc+4 is modulo 2^XLEN. Reaching (ROM_DEPTH*4) produces out-of-range fetches, not aliasing.
- pc itself has no output port. rom_addr is purely combinational from the pc register, with no dependency on inputs, so there is no combinational loop with the ROM.
- Reset asserted mid-stall or mid-redirect: reset wins and state returns to reset values. After release, the first edge fetches RESET_PC.

Decomposition:
- Package fetch_pkg: XLEN, NOP_INSTR=32'h0000_0013, RESET_PC default, typedef struct packed if_id_t {valid, fetch_err, pc, instr}.
- Sub-module pc_reg: PC register with next-PC mux (redirect/stall/+4), async active-low reset to RESET_PC, plus the misalign_err sticky flag.
- Top: IF/ID register, in_range check, rom_addr slice.

Test Plan:
- Reset then release, ROM preloaded with word i = 32'h1000_0000+i, no stall: on edges 1,2,3, if_id_pc=0,4,8, if_id_instr=1000_0000/0001/0002, valid=1. Before edge 1, valid=0 and instr=0000_0013.
- Stall held 3 cycles while if_id_pc=8: pc, rom_addr=3, and if_id_* remain unchanged. On release, the next edge gives if_id_pc=C.
- redirect=1 with redirect_pc=0x40 and stall=1 in the same cycle: next edge gives valid=0, instr=NOP, rom_addr=0x10. The following edge gives if_id_pc=0x40, instr=1000_0010.
- redirect_pc=0x42: misalign_err=1, pc=0x40. A later aligned redirect leaves misalign_err=1 until RESET_N=0.
- redirect_pc=0xFFC, then run 2 edges: if_id_pc=0xFFC with instr=ROM[1023] and fetch_err=0. Next, if_id_pc=0x1000, instr=NOP, fetch_err=1, valid=1.
- RESET_N pulsed low between clock edges mid-sequence: outputs go to reset values immediately, with no clock edge needed. After release, the fetch restarts at RESET_PC.
